// File: rtl/trigb_pkg.sv
// trigb_pkg: shared constants for the G.726 predictor-coefficient trigger block.
package trigb_pkg;

    // Predictor coefficients are 16-bit two's complement values.
    localparam int COEF_W = 16;

    // Value forced onto the coefficient while a transition is detected.
    localparam logic [COEF_W-1:0] COEF_ZERO = '0;

    // Observation register holds {TR, AnR}.
    localparam int OBS_W = COEF_W + 1;

endpackage

// File: rtl/trigb_obs_reg.sv
// trigb_obs_reg: observation/scan register for trigb, built only with TRIGB_OBS_EN.
// Captures {TR, AnR} every clock while scan_enable is low, and shifts as a
// scan chain (scan_in -> bit 0 -> ... -> bit OBS_W-1 -> scan_out) while
// scan_enable and test_mode are both high. scan_enable high with test_mode
// low holds the contents.
module trigb_obs_reg
    import trigb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_enable,
    input  logic             test_mode,
    input  logic             scan_in,
    input  logic [OBS_W-1:0] capture_data,
    output logic             scan_out
);

    logic [OBS_W-1:0] obs_q;

    // Capture, shift or hold the observation register; reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            obs_q <= '0;
        end else if (!scan_enable) begin
            obs_q <= capture_data;
        end else if (test_mode) begin
            obs_q <= {obs_q[OBS_W-2:0], scan_in};
        end
    end

    assign scan_out = obs_q[OBS_W-1];

endmodule

// File: rtl/trigb.sv
// trigb: G.726 predictor-coefficient trigger. AnR is forced to zero while the
// transition detector asserts TR, otherwise AnP passes through bit-exact.
// The datapath is purely combinational with zero latency.
// No handshake: AnR is a pure function of the current TR/AnP pair, so a new
// pair may be applied on any cycle or asynchronously to clk.
// Optional macro TRIGB_OBS_EN adds a 17-bit observation/scan register on
// chain 0 and passes chains 1..4 straight through; without it all scan
// outputs are tied low and chains are stitched later by DFT insertion.
module trigb
    import trigb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    input  logic              TR,
    input  logic [COEF_W-1:0] AnP,
    output logic [COEF_W-1:0] AnR,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4
);

    // Trigger mux: zero the coefficient on a transition, else pass it through.
    always_comb begin
        AnR = AnP;
        if (TR) begin
            AnR = COEF_ZERO;
        end
    end

`ifdef TRIGB_OBS_EN
    trigb_obs_reg u_obs_reg (
        .clk          (clk),
        .reset        (reset),
        .scan_enable  (scan_enable),
        .test_mode    (test_mode),
        .scan_in      (scan_in0),
        .capture_data ({TR, AnR}),
        .scan_out     (scan_out0)
    );

    assign scan_out1 = scan_in1;
    assign scan_out2 = scan_in2;
    assign scan_out3 = scan_in3;
    assign scan_out4 = scan_in4;
`else
    // DFT pins are inert in this build; fold them into one ignored net.
    logic unused_dft;
    assign unused_dft = ^{clk, reset, scan_in0, scan_in1, scan_in2, scan_in3,
                          scan_in4, scan_enable, test_mode};

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;
`endif

endmodule

// File: tb/tb_trigb.sv
// tb_trigb: directed-vector bench for trigb (optional TRIGB_OBS_EN section).
module tb_trigb;

    localparam int CW = 16;
    localparam int SW = 21;  // {scan_out4..scan_out0, AnR}

    logic          clk;
    logic          reset;
    logic          scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic          scan_enable;
    logic          test_mode;
    logic          tr;
    logic [CW-1:0] anp;
    logic [CW-1:0] anr;
    logic          scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    trigb dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .TR          (tr),
        .AnP         (anp),
        .AnR         (anr),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

`ifdef TRIGB_OBS_EN
    // Scan outputs are covered by the dedicated observation checks.
    localparam logic [SW-1:0] CMP_MASK = {5'b00000, {CW{1'b1}}};
`else
    localparam logic [SW-1:0] CMP_MASK = {SW{1'b1}};
`endif

    // ---------------- scoreboard ----------------
    logic [SW-1:0] exp_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    event          sample_ev;

    task automatic check(input string name, input logic [SW-1:0] act,
                         input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the driver says the outputs have settled, pop and compare.
    initial begin
        logic [SW-1:0] e;
        string         nm;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL monitor: output sampled with no expected value queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0, anr} & CMP_MASK,
                      e & CMP_MASK);
            end
        end
    end

    // ---------------- driver ----------------
    // Apply one TR/AnP pair with its expected AnR (scan outputs expected 0),
    // let it settle for less than the 10 ns budget, then hand to the monitor.
    task automatic apply(input string name, input logic t, input logic [CW-1:0] a,
                         input logic [CW-1:0] exp_anr, input int settle);
        exp_q.push_back({5'b00000, exp_anr});
        name_q.push_back(name);
        tr  = t;
        anp = a;
        #(settle);
        ->sample_ev;
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [CW-1:0] v;
        reset = 1'b1;
        scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0;
        scan_in3 = 1'b0; scan_in4 = 1'b0;
        scan_enable = 1'b0;
        test_mode   = 1'b0;
        tr  = 1'b0;
        anp = 16'h5555;

        // During reset AnR still follows AnP; scan outputs are low.
        repeat (2) @(posedge clk);
        #3;
        apply("reset_pass", 1'b0, 16'h5555, 16'h5555, 5);
        apply("reset_trig", 1'b1, 16'h5555, 16'h0000, 5);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        apply("pass_1a2b",   1'b0, 16'h1A2B, 16'h1A2B, 9);
        apply("trig_f3c0",   1'b1, 16'hF3C0, 16'h0000, 9);
        apply("tog0_8000",   1'b0, 16'h8000, 16'h8000, 9);
        apply("tog1_8000",   1'b1, 16'h8000, 16'h0000, 9);
        apply("tog2_8000",   1'b0, 16'h8000, 16'h8000, 9);
        apply("pass_ffff",   1'b0, 16'hFFFF, 16'hFFFF, 9);
        apply("pass_7fff",   1'b0, 16'h7FFF, 16'h7FFF, 9);
        apply("pass_0001",   1'b0, 16'h0001, 16'h0001, 9);
        apply("trig_ffff",   1'b1, 16'hFFFF, 16'h0000, 9);
        apply("trig_0000",   1'b1, 16'h0000, 16'h0000, 9);
        apply("pass_a5a5",   1'b0, 16'hA5A5, 16'hA5A5, 9);
        apply("pass_5a5a",   1'b0, 16'h5A5A, 16'h5A5A, 9);

        // Full sweep, TR=0 then TR=1, with reset pulsed mid-sweep.
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 65536; i++) begin
                if (p == 0 && i == 30000) reset = 1'b1;
                if (p == 0 && i == 31000) reset = 1'b0;
                v = i[CW-1:0];
                apply(p == 0 ? "sweep_pass" : "sweep_trig", p[0], v,
                      p == 0 ? v : 16'h0000, 1);
            end
        end
        reset = 1'b0;

`ifdef TRIGB_OBS_EN
        begin
            logic [16:0] cap;
            cap = 17'h10000;
            // Capture {TR=1, AnR=0}: only bit 16 set, visible on scan_out0.
            @(negedge clk);
            tr = 1'b1; anp = 16'h1234; scan_enable = 1'b0; test_mode = 1'b0;
            @(posedge clk); #1;
            check("obs_capture", {20'd0, scan_out0}, 21'd1);
            // Reset clears the register.
            @(negedge clk); reset = 1'b1;
            @(posedge clk); #1;
            check("obs_reset", {20'd0, scan_out0}, 21'd0);
            @(negedge clk); reset = 1'b0;
            @(posedge clk); #1;
            check("obs_recapture", {20'd0, scan_out0}, 21'd1);
            // Shift out MSB first; chains 1..4 pass straight through.
            @(negedge clk);
            scan_enable = 1'b1; test_mode = 1'b1; scan_in0 = 1'b0;
            scan_in1 = 1'b1; scan_in2 = 1'b0; scan_in3 = 1'b1; scan_in4 = 1'b0;
            #1;
            check("obs_thru", {17'd0, scan_out4, scan_out3, scan_out2, scan_out1},
                  {17'd0, 4'b0101});
            for (int k = 0; k < 17; k++) begin
                check("obs_shift", {20'd0, scan_out0}, {20'd0, cap[16-k]});
                @(posedge clk); #1;
            end
            scan_enable = 1'b0; test_mode = 1'b0;
        end
`endif

        #5;
        check("queue_drained", SW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
